// File: rtl/decodificador_instrucao_fila_pkg.sv
// Shared field widths, opcode constants and helpers for the coprocessor instruction decoder.
package pkg_coprocessador;

  localparam int unsigned CAMPO_INSTR_W = 32;
  localparam int unsigned CAMPO_OPC_W   = 4;
  localparam int unsigned CAMPO_IDX_W   = 3;
  localparam int unsigned CAMPO_DATA_W  = 16;
  localparam int unsigned CAMPO_MAT_W   = 2;
  localparam int unsigned CAMPO_DEPTH   = 4;
  localparam int unsigned CAMPO_CNT_W   = 16;

  // Bit k set -> opcode k is accepted by the coprocessor
  localparam logic [15:0] MASCARA_LEGAL_PADRAO = 16'h00FF;

  localparam logic [CAMPO_OPC_W-1:0] OP_NOP       = 4'h0;
  localparam logic [CAMPO_OPC_W-1:0] OP_LER       = 4'h1;
  localparam logic [CAMPO_OPC_W-1:0] OP_ESCREVER  = 4'h2;
  localparam logic [CAMPO_OPC_W-1:0] OP_SOMA      = 4'h3;
  localparam logic [CAMPO_OPC_W-1:0] OP_SUBTRAI   = 4'h4;
  localparam logic [CAMPO_OPC_W-1:0] OP_MULTIPLICA = 4'h5;
  localparam logic [CAMPO_OPC_W-1:0] OP_TRANSPOE  = 4'h6;
  localparam logic [CAMPO_OPC_W-1:0] OP_ZERA_MAT  = 4'h7;

  // Output stage holds a decoded instruction or is empty
  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

  // Decoded payload for the default field layout, MSB first
  typedef struct packed {
    logic [CAMPO_OPC_W-1:0]  opcode;
    logic [CAMPO_IDX_W-1:0]  linha;
    logic [CAMPO_IDX_W-1:0]  coluna;
    logic [CAMPO_DATA_W-1:0] dado;
    logic [CAMPO_MAT_W-1:0]  id_matriz;
  } campos_t;

  // Splits a default-layout instruction word into its fields; trailing LSBs are dropped
  function automatic campos_t extrai_campos(input logic [CAMPO_INSTR_W-1:0] palavra);
    return campos_t'(palavra >> (CAMPO_INSTR_W - $bits(campos_t)));
  endfunction

endpackage

// File: rtl/decodificador_instrucao_fila_fifo.sv
// Synchronous FIFO with occupancy count, synchronous reset and flush.
module fifo_sincrona #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         limpa,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || limpa) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decodificador_instrucao_fila.sv
// Buffers host instruction words and hands decoded legal ones to the coprocessor control FSM.
module decodificador_instrucao_fila
  import pkg_coprocessador::*;
#(
  parameter int unsigned              INSTR_W   = CAMPO_INSTR_W,
  parameter int unsigned              OPC_W     = CAMPO_OPC_W,
  parameter int unsigned              IDX_W     = CAMPO_IDX_W,
  parameter int unsigned              DATA_W    = CAMPO_DATA_W,
  parameter int unsigned              MAT_W     = CAMPO_MAT_W,
  parameter int unsigned              DEPTH     = CAMPO_DEPTH,
  parameter logic [(2**OPC_W)-1:0]    OPC_LEGAL = MASCARA_LEGAL_PADRAO,
  parameter int unsigned              CNT_W     = CAMPO_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        limpa,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [INSTR_W-1:0]          instrucao,
  output logic                        dec_valid,
  input  logic                        dec_ready,
  output logic [OPC_W-1:0]            opcode,
  output logic [IDX_W-1:0]            linha,
  output logic [IDX_W-1:0]            coluna,
  output logic [DATA_W-1:0]           dado,
  output logic [MAT_W-1:0]            id_matriz,
  output logic                        erro_opcode,
  output logic                        erro_sticky,
  output logic [$clog2(DEPTH+1)-1:0]  ocupacao,
  output logic [CNT_W-1:0]            cont_instr
);

  localparam int unsigned USED_W = OPC_W + 2*IDX_W + DATA_W + MAT_W;
  localparam int unsigned OPC_LO = INSTR_W - OPC_W;
  localparam int unsigned LIN_LO = OPC_LO - IDX_W;
  localparam int unsigned COL_LO = LIN_LO - IDX_W;
  localparam int unsigned DAT_LO = COL_LO - DATA_W;
  localparam int unsigned MAT_LO = DAT_LO - MAT_W;

  // Elaboration-time parameter sanity checks
  if (INSTR_W < USED_W) begin : g_chk_largura
    $error("INSTR_W too narrow for the configured field widths");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] head;
  logic               push_c;
  logic               pop_c;
  logic               load_c;
  logic               err_c;
  logic               inc_c;
  logic               legal_c;
  logic [OPC_W-1:0]   head_opc;
  logic               unused_head;
  estado_t            state_q;
  estado_t            state_d;

  assign instr_ready = !fifo_full && !limpa && !rst;
  assign push_c      = instr_valid && instr_ready;
  assign head_opc    = head[OPC_LO +: OPC_W];
  assign legal_c     = OPC_LEGAL[head_opc];
  assign dec_valid   = (state_q == CHEIO);
  assign unused_head = ^head;

  fifo_sincrona #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .limpa (limpa),
    .push  (push_c),
    .pop   (pop_c),
    .din   (instrucao),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ocupacao)
  );

  // Output-stage state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VAZIO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus pop/load/error/count strobes; a free or draining stage evaluates the FIFO head
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    load_c  = 1'b0;
    err_c   = 1'b0;
    inc_c   = 1'b0;
    if (limpa) begin
      state_d = VAZIO;
    end else begin
      case (state_q)
        VAZIO: begin
          if (!fifo_empty) begin
            pop_c = 1'b1;
            if (legal_c) begin
              load_c  = 1'b1;
              state_d = CHEIO;
            end else begin
              err_c = 1'b1;
            end
          end
        end
        CHEIO: begin
          if (dec_ready) begin
            inc_c   = 1'b1;
            state_d = VAZIO;
            if (!fifo_empty) begin
              pop_c = 1'b1;
              if (legal_c) begin
                load_c  = 1'b1;
                state_d = CHEIO;
              end else begin
                err_c = 1'b1;
              end
            end
          end
        end
        default: state_d = VAZIO;
      endcase
    end
  end

  // Decoded field register, error flags and dispatch counter
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode      <= '0;
      linha       <= '0;
      coluna      <= '0;
      dado        <= '0;
      id_matriz   <= '0;
      erro_opcode <= 1'b0;
      erro_sticky <= 1'b0;
      cont_instr  <= '0;
    end else begin
      if (load_c) begin
        opcode    <= head[OPC_LO +: OPC_W];
        linha     <= head[LIN_LO +: IDX_W];
        coluna    <= head[COL_LO +: IDX_W];
        dado      <= head[DAT_LO +: DATA_W];
        id_matriz <= head[MAT_LO +: MAT_W];
      end
      erro_opcode <= err_c;
      erro_sticky <= limpa ? 1'b0 : (erro_sticky || err_c);
      if (inc_c) begin
        cont_instr <= cont_instr + CNT_W'(1);
      end
    end
  end

endmodule
